rgb_breath_array: RTL and testbench

- Parametrised successor to the single adjustable rainbow breathing LED.
- Drives NUM_CH RGB LEDs from one shared breathing engine. Each channel shows a palette colour offset by its channel index.
- NUM_SPEEDS speed levels, set by debounced up/down buttons. Four display modes.
- Colour advance is either timer-based or locked to the breathing trough.
- Sits between board buttons/switches and the RGB LED pins.

---
 rtl/rgb_breath_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 45 ++++
 rtl/rgb_breath_array.sv | 212 +++++++++++++++++++++
 tb/tb_rgb_breath_array.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_breath_pkg.sv
// Shared definitions for the RGB breathing array: display modes, colour palette
// and the palette index arithmetic used by every channel.
package rgb_breath_pkg;

    localparam int unsigned NUM_COLORS = 7;

    typedef enum logic [1:0] {
        MODE_BREATHE = 2'b00,
        MODE_STEADY  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_OFF     = 2'b11
    } mode_t;

    // Percent values per palette entry, ordered {R, G, B}
    localparam logic [6:0] PALETTE [NUM_COLORS][3] = '{
        '{7'd100, 7'd0,   7'd0  },
        '{7'd100, 7'd40,  7'd0  },
        '{7'd100, 7'd100, 7'd0  },
        '{7'd0,   7'd100, 7'd0  },
        '{7'd0,   7'd0,   7'd100},
        '{7'd100, 7'd0,   7'd100},
        '{7'd100, 7'd100, 7'd100}
    };

    function automatic logic [2:0] color_add(input logic [2:0] base, input logic [2:0] ofs);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, ofs};
        if (s >= 4'(NUM_COLORS)) s = s - 4'(NUM_COLORS);
        return s[2:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a single-cycle
// pulse on each accepted press (release is accepted silently).
module btn_debounce #(
    parameter int unsigned CLK_FREQ    = 125000000,
    parameter int unsigned DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned DB_CNT = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int unsigned CW     = $clog2(DB_CNT + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            // Any return to the accepted level restarts the stability window
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CNT - 1)) begin
                cnt    <= '0;
                stable <= sync2;
                pulse  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_breath_array.sv
// NUM_CH RGB LEDs driven by one shared breathing engine with selectable speed,
// four display modes and a palette offset by channel index.
module rgb_breath_array
    import rgb_breath_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 125000000,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned NUM_SPEEDS     = 4,
    parameter int unsigned BASE_PERIOD_MS = 2000,
    parameter int unsigned MAX_BRIGHT     = 100,
    parameter int unsigned PWM_PERIOD     = 200,
    parameter int unsigned COLOR_HOLD_MS  = 1000,
    parameter int unsigned COLOR_SYNC     = 0,
    parameter int unsigned DEBOUNCE_MS    = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              btn_up,
    input  logic                              btn_dn,
    input  logic [1:0]                        mode_sel,
    output logic [NUM_SPEEDS-1:0]             led_mode,
    output logic [2:0]                        color_idx,
    output logic [$clog2(MAX_BRIGHT+1)-1:0]   bright,
    output logic [NUM_CH-1:0]                 led_r,
    output logic [NUM_CH-1:0]                 led_g,
    output logic [NUM_CH-1:0]                 led_b
);

    localparam int unsigned CLK_PER_MS = CLK_FREQ / 1000;
    localparam int unsigned STEP0      = CLK_PER_MS * BASE_PERIOD_MS / (2 * MAX_BRIGHT);
    localparam int unsigned SPW        = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
    localparam int unsigned SW         = $clog2(STEP0 + 1);
    localparam int unsigned BW         = $clog2(MAX_BRIGHT + 1);
    localparam int unsigned MW         = $clog2(CLK_PER_MS + 1);
    localparam int unsigned HW         = $clog2(COLOR_HOLD_MS + 1);
    localparam int unsigned PW         = $clog2(PWM_PERIOD + 1);
    localparam int unsigned DIV        = MAX_BRIGHT * 100;
    localparam logic [BW-1:0] MAXB     = BW'(MAX_BRIGHT);

    logic            up_p, dn_p;
    logic            up_ok, dn_ok, speed_chg;
    logic [SPW-1:0]  speed;
    logic [MW-1:0]   ms_cnt;
    logic            tick_1ms;
    logic [HW-1:0]   hold_cnt;
    logic [SW-1:0]   step_cnt, step_lim;
    logic            step_tick;
    mode_t           mode_q;
    logic            dir_up, dir_up_nx;
    logic [BW-1:0]   bright_nx;
    logic [BW-1:0]   blink_cnt, blink_nx;
    logic            trough;
    logic            color_adv;
    logic [PW-1:0]   pwm_cnt;

    logic [NUM_CH-1:0][PW-1:0] duty_nx  [3];
    logic [NUM_CH-1:0][PW-1:0] duty_eff [3];
    logic [NUM_CH-1:0][PW-1:0] duty_q   [3];
    logic [NUM_CH-1:0]         led_nx   [3];

    btn_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn(btn_up), .pulse(up_p)
    );

    btn_debounce #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_dn (
        .clk(clk), .rst_n(rst_n), .btn(btn_dn), .pulse(dn_p)
    );

    assign up_ok     = up_p && !dn_p && (speed != SPW'(NUM_SPEEDS - 1));
    assign dn_ok     = dn_p && !up_p && (speed != '0);
    assign speed_chg = up_ok || dn_ok;
    assign step_lim  = SW'(STEP0) >> speed;
    assign step_tick = (step_cnt == step_lim - 1'b1) && !speed_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt   <= '0;
            tick_1ms <= 1'b0;
            speed    <= '0;
            led_mode <= NUM_SPEEDS'(1);
            step_cnt <= '0;
            mode_q   <= MODE_BREATHE;
        end else begin
            if (ms_cnt == MW'(CLK_PER_MS - 1)) begin
                ms_cnt   <= '0;
                tick_1ms <= 1'b1;
            end else begin
                ms_cnt   <= ms_cnt + 1'b1;
                tick_1ms <= 1'b0;
            end
            if (up_ok)      speed <= speed + 1'b1;
            else if (dn_ok) speed <= speed - 1'b1;
            led_mode <= NUM_SPEEDS'(1) << speed;
            if (speed_chg || step_tick) step_cnt <= '0;
            else                        step_cnt <= step_cnt + 1'b1;
            mode_q <= mode_t'(mode_sel);
        end
    end

    always_comb begin
        bright_nx = bright;
        dir_up_nx = dir_up;
        blink_nx  = blink_cnt;
        trough    = 1'b0;
        case (mode_q)
            MODE_BREATHE: begin
                blink_nx = '0;
                if (step_tick) begin
                    if (dir_up) begin
                        // Entering from a lit mode at full scale turns straight back down
                        if (bright >= MAXB) begin
                            bright_nx = bright - 1'b1;
                            dir_up_nx = 1'b0;
                        end else begin
                            bright_nx = bright + 1'b1;
                            trough    = (bright == '0);
                            if (bright == MAXB - 1'b1) dir_up_nx = 1'b0;
                        end
                    end else if (bright == '0) begin
                        bright_nx = BW'(1);
                        dir_up_nx = 1'b1;
                        trough    = 1'b1;
                    end else begin
                        bright_nx = bright - 1'b1;
                        if (bright == BW'(1)) dir_up_nx = 1'b1;
                    end
                end
            end
            MODE_STEADY: begin
                bright_nx = MAXB;
                dir_up_nx = 1'b1;
                blink_nx  = '0;
            end
            MODE_BLINK: begin
                dir_up_nx = 1'b1;
                if (step_tick) begin
                    if (blink_cnt == MAXB - 1'b1) begin
                        blink_nx = '0;
                        if (bright == '0) begin
                            bright_nx = MAXB;
                            trough    = 1'b1;
                        end else begin
                            bright_nx = '0;
                        end
                    end else begin
                        blink_nx = blink_cnt + 1'b1;
                    end
                end
            end
            default: begin
                bright_nx = '0;
                dir_up_nx = 1'b1;
                blink_nx  = '0;
            end
        endcase
    end

    assign color_adv = (COLOR_SYNC != 0) ? trough
                     : (tick_1ms && (hold_cnt == HW'(COLOR_HOLD_MS - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright    <= '0;
            dir_up    <= 1'b1;
            blink_cnt <= '0;
            hold_cnt  <= '0;
            color_idx <= '0;
        end else begin
            bright    <= bright_nx;
            dir_up    <= dir_up_nx;
            blink_cnt <= blink_nx;
            if (tick_1ms) begin
                if (hold_cnt == HW'(COLOR_HOLD_MS - 1)) hold_cnt <= '0;
                else                                    hold_cnt <= hold_cnt + 1'b1;
            end
            if (color_adv) color_idx <= (color_idx == 3'(NUM_COLORS - 1)) ? 3'd0 : color_idx + 3'd1;
        end
    end

    // Duty is recomputed every cycle but only committed at the start of a PWM period
    always_comb begin
        duty_nx  = '{default: '0};
        duty_eff = '{default: '0};
        led_nx   = '{default: '0};
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                duty_nx[c][k]  = PW'((64'(bright) * 64'(PALETTE[color_add(color_idx, 3'(k))][c])
                                      * 64'(PWM_PERIOD)) / 64'(DIV));
                duty_eff[c][k] = (pwm_cnt == '0) ? duty_nx[c][k] : duty_q[c][k];
                led_nx[c][k]   = (mode_t'(mode_sel) != MODE_OFF) && (pwm_cnt < duty_eff[c][k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            duty_q  <= '{default: '0};
            led_r   <= '0;
            led_g   <= '0;
            led_b   <= '0;
        end else begin
            if (pwm_cnt == PW'(PWM_PERIOD - 1)) pwm_cnt <= '0;
            else                                pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '0) duty_q <= duty_nx;
            led_r <= led_nx[0];
            led_g <= led_nx[1];
            led_b <= led_nx[2];
        end
    end

endmodule

// File: tb/tb_rgb_breath_array.sv
// Self-checking bench for rgb_breath_array: speed table, random presses against
// a saturating-counter model, triangle-wave breathing/colour model and PWM duty counts.
module tb_rgb_breath_array;

    localparam int unsigned CLK_FREQ       = 100000;
    localparam int unsigned NUM_CH         = 2;
    localparam int unsigned NUM_SPEEDS     = 4;
    localparam int unsigned BASE_PERIOD_MS = 200;
    localparam int unsigned MAX_BRIGHT     = 100;
    localparam int unsigned PWM_PERIOD     = 200;
    localparam int unsigned COLOR_HOLD_MS  = 1000;
    localparam int unsigned DEBOUNCE_MS    = 4;
    localparam int unsigned CPM            = CLK_FREQ / 1000;
    localparam int unsigned STEP0          = CPM * BASE_PERIOD_MS / (2 * MAX_BRIGHT);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  btn_up = 1'b0;
    logic                  btn_dn = 1'b0;
    logic [1:0]            mode_sel = 2'b00;
    logic [NUM_SPEEDS-1:0] led_mode;
    logic [2:0]            color_idx;
    logic [6:0]            bright;
    logic [NUM_CH-1:0]     led_r, led_g, led_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int unsigned PR [7] = '{100, 100, 100, 0,   0,   100, 100};
    int unsigned PG [7] = '{0,   40,  100, 100, 0,   0,   100};
    int unsigned PB [7] = '{0,   0,   0,   0,   100, 100, 100};
    int unsigned pc [NUM_CH][3];

    typedef struct {
        logic        up;
        logic        dn;
        logic        chatter;
        int unsigned hold;
        logic [3:0]  exp_mode;
    } pvec_t;
    pvec_t pv [8];

    rgb_breath_array #(
        .CLK_FREQ(CLK_FREQ), .NUM_CH(NUM_CH), .NUM_SPEEDS(NUM_SPEEDS),
        .BASE_PERIOD_MS(BASE_PERIOD_MS), .MAX_BRIGHT(MAX_BRIGHT), .PWM_PERIOD(PWM_PERIOD),
        .COLOR_HOLD_MS(COLOR_HOLD_MS), .COLOR_SYNC(1), .DEBOUNCE_MS(DEBOUNCE_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .mode_sel(mode_sel),
        .led_mode(led_mode), .color_idx(color_idx), .bright(bright),
        .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int unsigned tri_wave(input int unsigned p);
        int unsigned q;
        q = p % (2 * MAX_BRIGHT);
        return (q <= MAX_BRIGHT) ? q : 2 * MAX_BRIGHT - q;
    endfunction

    function automatic int unsigned pct(input int unsigned idx, input int unsigned c);
        return (c == 0) ? PR[idx] : (c == 1) ? PG[idx] : PB[idx];
    endfunction

    task automatic press(input logic u, input logic d, input logic chat, input int unsigned hold);
        for (int unsigned t = 0; t < hold; t++) begin
            btn_up = u & (!chat || ((t / 40) % 2 == 0));
            btn_dn = d & (!chat || ((t / 40) % 2 == 0));
            tick(1);
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick(600);
    endtask

    task automatic release_checks(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check({tag, "_leds_after_release"}, {led_r, led_g, led_b}, 0);
        tick(STEP0 - 2);
        check({tag, "_bright_before_step"}, bright, 0);
        tick(1);
        check({tag, "_bright_first_step"}, bright, 1);
        check({tag, "_color_first_trough"}, color_idx, 1);
        check({tag, "_mode_after_release"}, led_mode, 1);
    endtask

    task automatic reset_scenario(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        mode_sel = 2'b00;
        btn_up   = 1'b0;
        btn_dn   = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_rst_led_mode"}, led_mode, 1);
        check({tag, "_rst_color"}, color_idx, 0);
        check({tag, "_rst_bright"}, bright, 0);
        check({tag, "_rst_leds"}, {led_r, led_g, led_b}, 0);
        release_checks(tag);
    endtask

    task automatic count_pwm();
        for (int unsigned k = 0; k < NUM_CH; k++)
            for (int unsigned c = 0; c < 3; c++) pc[k][c] = 0;
        for (int unsigned t = 0; t < PWM_PERIOD; t++) begin
            tick(1);
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                pc[k][0] += led_r[k];
                pc[k][1] += led_g[k];
                pc[k][2] += led_b[k];
            end
        end
    endtask

    task automatic steady_check(input int unsigned base, input string tag);
        mode_sel = 2'b01;
        tick(2 * PWM_PERIOD + 5);
        check({tag, "_steady_bright"}, bright, MAX_BRIGHT);
        count_pwm();
        for (int unsigned k = 0; k < NUM_CH; k++)
            for (int unsigned c = 0; c < 3; c++)
                check($sformatf("%s_ch%0d_c%0d_high", tag, k, c), pc[k][c],
                      MAX_BRIGHT * pct((base + k) % 7, c) * PWM_PERIOD / (MAX_BRIGHT * 100));
    endtask

    task automatic wait_color_change(input logic [2:0] from, input logic [2:0] exp, input string tag);
        int unsigned n;
        n = 0;
        while (color_idx == from && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_in_time"}, (n < 3000) ? 1 : 0, 1);
        check({tag, "_value"}, color_idx, exp);
    endtask

    initial begin
        int unsigned ms;
        int unsigned kind;
        int unsigned n;
        int          t1;
        int          errs;
        logic        u, d;

        pv[0] = '{1'b1, 1'b0, 1'b0, 600, 4'b0010};
        pv[1] = '{1'b1, 1'b0, 1'b0, 600, 4'b0100};
        pv[2] = '{1'b1, 1'b0, 1'b0, 600, 4'b1000};
        pv[3] = '{1'b1, 1'b0, 1'b0, 600, 4'b1000};
        pv[4] = '{1'b1, 1'b0, 1'b0, 600, 4'b1000};
        pv[5] = '{1'b0, 1'b1, 1'b1, 200, 4'b1000};
        pv[6] = '{1'b0, 1'b1, 1'b0, 600, 4'b0100};
        pv[7] = '{1'b1, 1'b1, 1'b0, 600, 4'b0100};

        reset_scenario("reset");

        for (int i = 0; i < 8; i++) begin
            press(pv[i].up, pv[i].dn, pv[i].chatter, pv[i].hold);
            check($sformatf("speed_vec%0d", i), led_mode, pv[i].exp_mode);
        end

        ms = 2;
        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 3);
            u = (kind == 0 || kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
            d = (kind == 1 || kind == 2) || (kind == 3 && !u);
            press(u, d, 1'b0, (kind == 3) ? $urandom_range(5, 300) : 600);
            if (kind == 0 && ms < NUM_SPEEDS - 1) ms++;
            if (kind == 1 && ms > 0) ms--;
            check($sformatf("rand_press%0d_k%0d", i, kind), led_mode, 1 << ms);
        end

        reset_scenario("reset2");
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0, 600);
        check("speed3", led_mode, 4'b1000);
        mode_sel = 2'b11;
        tick(20);
        check("off_bright", bright, 0);
        check("off_color_held", color_idx, 1);

        mode_sel = 2'b00;
        n = 0;
        while (bright != 1 && n < 40) begin
            tick(1);
            n++;
        end
        check("breathe_start_in_time", (n < 40) ? 1 : 0, 1);
        t1 = cyc;
        check("breathe_start_trough", color_idx, 2);
        errs = 0;
        for (int i = 0; i < 900 * (STEP0 >> 3); i++) begin
            tick(1);
            n = (cyc - t1) / (STEP0 >> 3);
            if (bright != tri_wave(1 + n) || color_idx != (2 + n / 200) % 7) begin
                if (errs == 0)
                    $display("trace deviation at step %0d: bright=%0d color=%0d", n, bright, color_idx);
                errs++;
            end
        end
        check("breathe_trace_errors", errs, 0);
        check("trace_peak_reached_after_99_steps", tri_wave(1 + 99), MAX_BRIGHT);
        check("trace_end_color", color_idx, 6);

        steady_check(6, "white_red");
        mode_sel = 2'b00;
        wait_color_change(3'd6, 3'd0, "wrap6to0");
        wait_color_change(3'd0, 3'd1, "next_orange");
        steady_check(1, "orange");

        mode_sel = 2'b11;
        tick(1);
        check("off_leds_one_clock", {led_r, led_g, led_b}, 0);
        tick(2);
        check("off_bright_zero", bright, 0);

        press(1'b0, 1'b1, 1'b0, 600);
        check("speed2", led_mode, 4'b0100);
        mode_sel = 2'b00;
        n = 0;
        while (bright != 57 && n < 3000) begin
            tick(1);
            n++;
        end
        check("bright57_in_time", (n < 3000) ? 1 : 0, 1);
        rst_n = 1'b0;
        #2;
        check("midrst_bright", bright, 0);
        check("midrst_led_mode", led_mode, 1);
        check("midrst_color", color_idx, 0);
        check("midrst_leds", {led_r, led_g, led_b}, 0);
        release_checks("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
